ifu_iccm_mem_nb: RTL

- Parametrised ICCM storage array; next generation of the fixed 4-quadrant ICCM.
- Supports a configurable bank count, unaligned 4-word fetch with bank rotation, and 32- or 64-bit writes.
- Registered read data path with `iccm_rd_valid`, plus a post-reset hardware clear engine that zeroes every word (zero data is valid ECC).
- Sits between the IFU fetch/DMA arbitration and the SRAM banks; behavioural per-bank arrays are inferred.

---
 rtl/ifu_iccm_mem_nb.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ifu_iccm_mem_nb.sv
// ifu_iccm_mem_nb: banked ICCM storage array.
// Words are interleaved across NUM_BANKS 39-bit banks (bank = low word-address
// bits). A fetch reads every bank at its own index and rotates the bank outputs
// so that word0 of iccm_rd_data is the addressed word. Writes cover one word, or
// two consecutive words for a 64-bit write. After reset a clear engine zeroes
// every row (all-zero is a valid ECC codeword) before requests are accepted.
module ifu_iccm_mem_nb #(
  parameter int ICCM_BITS = 16,
  parameter int NUM_BANKS = 8,
  parameter int RD_PIPE   = 0,
  parameter int INIT_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 clk_override,
  input  logic                 scan_mode,
  input  logic                 iccm_wren,
  input  logic                 iccm_rden,
  input  logic [ICCM_BITS-3:0] iccm_rw_addr,
  input  logic [2:0]           iccm_wr_size,
  input  logic [77:0]          iccm_wr_data,
  output logic [155:0]         iccm_rd_data,
  output logic                 iccm_rd_valid,
  output logic                 iccm_ready,
  output logic                 iccm_rw_conflict
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int AW        = ICCM_BITS - 2;
  localparam int IDX_W     = AW - BANK_BITS;
  localparam int DEPTH     = 1 << IDX_W;

  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
  localparam logic [AW-1:0]    ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_READY;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] init_cnt_r;
  logic [IDX_W-1:0] init_cnt_nxt_s;
  logic             init_s;
  logic             ready_r;

  // Clear-engine state, row counter and the registered ready flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r    <= RST_STATE;
      init_cnt_r <= {IDX_W{1'b0}};
      ready_r    <= (INIT_EN == 0);
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
      ready_r    <= (state_nxt_s == ST_READY);
    end
  end

  // Clear-engine next state: sweep every row once, then hand over to requests.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    init_s         = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_s         = 1'b1;
        init_cnt_nxt_s = init_cnt_r + IDX_ONE;
        if (init_cnt_r == IDX_LAST) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_READY: begin
        state_nxt_s = ST_READY;
      end
      default: begin
        state_nxt_s = RST_STATE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [BANK_BITS-1:0] a_bank_s;
  logic [IDX_W-1:0]     a_idx_s;
  logic [AW-1:0]        a1_s;
  logic [BANK_BITS-1:0] a1_bank_s;
  logic                 wr64_s;
  logic                 wr_acc_s;
  logic                 rd_acc_s;

  assign a_bank_s  = iccm_rw_addr[BANK_BITS-1:0];
  assign a_idx_s   = iccm_rw_addr[AW-1:BANK_BITS];
  assign a1_s      = iccm_rw_addr + ADDR_ONE;
  assign a1_bank_s = a1_s[BANK_BITS-1:0];
  assign wr64_s    = (iccm_wr_size[1:0] == 2'b11);
  assign wr_acc_s  = ready_r & iccm_wren;
  assign rd_acc_s  = ready_r & iccm_rden & ~iccm_wren;

  // Size bit 2 carries no meaning for this array.
  logic unused_wr_size_s;
  assign unused_wr_size_s = iccm_wr_size[2];

  // ---------------------------------------------------------------------------
  // Per-bank index, write select and clock enable
  // ---------------------------------------------------------------------------
  logic [NUM_BANKS-1:0]            bank_we_s;
  logic [NUM_BANKS-1:0]            bank_clken_s;
  logic [NUM_BANKS-1:0]            bank_gate_s;
  logic [NUM_BANKS-1:0][IDX_W-1:0] bank_idx_s;
  logic [NUM_BANKS-1:0][38:0]      bank_wd_s;
  logic [NUM_BANKS-1:0][38:0]      bank_dout_s;

  // Banks below the start bank hold words past the bank wrap, one row further
  // on; the same per-bank index serves the read window and both write words.
  always_comb begin
    bank_we_s    = {NUM_BANKS{1'b0}};
    bank_clken_s = {NUM_BANKS{1'b0}};
    bank_gate_s  = {NUM_BANKS{1'b0}};
    bank_idx_s   = {(NUM_BANKS*IDX_W){1'b0}};
    bank_wd_s    = {(NUM_BANKS*39){1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (init_s) begin
        bank_idx_s[b] = init_cnt_r;
        bank_we_s[b]  = 1'b1;
        bank_wd_s[b]  = 39'b0;
      end else begin
        if (BANK_BITS'(b) < a_bank_s) begin
          bank_idx_s[b] = a_idx_s + IDX_ONE;
        end else begin
          bank_idx_s[b] = a_idx_s;
        end
        if (wr_acc_s && (BANK_BITS'(b) == a_bank_s)) begin
          bank_we_s[b] = 1'b1;
          bank_wd_s[b] = iccm_wr_data[38:0];
        end else if (wr_acc_s && wr64_s && (BANK_BITS'(b) == a1_bank_s)) begin
          bank_we_s[b] = 1'b1;
          bank_wd_s[b] = iccm_wr_data[77:39];
        end else begin
          bank_we_s[b] = 1'b0;
          bank_wd_s[b] = 39'b0;
        end
      end
      bank_clken_s[b] = bank_we_s[b] | rd_acc_s | init_s | clk_override;
      // Clock-header model: scan forces the bank clock on.
      bank_gate_s[b]  = bank_clken_s[b] | scan_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank arrays
  // ---------------------------------------------------------------------------
  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    logic [38:0] mem [DEPTH];
    logic [38:0] dout_r;

    // Array write: only a clocked bank with its write select set updates.
    always_ff @(posedge clk) begin
      if (bank_gate_s[gb] && bank_we_s[gb]) begin
        mem[bank_idx_s[gb]] <= bank_wd_s[gb];
      end
    end

    // Bank read register, loaded on each accepted read, held otherwise.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        dout_r <= 39'b0;
      end else if (bank_gate_s[gb] && rd_acc_s) begin
        dout_r <= mem[bank_idx_s[gb]];
      end
    end

    assign bank_dout_s[gb] = dout_r;
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  logic [BANK_BITS-1:0] rd_off_r;
  logic                 rd_vld_r;
  logic                 conflict_r;
  logic [155:0]         rot_s;

  // Read tracking: rotation offset of the last fetch, valid, conflict pulse.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_off_r   <= {BANK_BITS{1'b0}};
      rd_vld_r   <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      rd_vld_r   <= rd_acc_s;
      conflict_r <= ready_r & iccm_rden & iccm_wren;
      if (rd_acc_s) begin
        rd_off_r <= a_bank_s;
      end
    end
  end

  // Rotate bank outputs so word k comes from bank (offset + k) mod NUM_BANKS.
  always_comb begin
    rot_s = {156{1'b0}};
    for (int k = 0; k < 4; k++) begin
      rot_s[39*k +: 39] = bank_dout_s[rd_off_r + BANK_BITS'(k)];
    end
  end

  if (RD_PIPE != 0) begin : g_pipe
    logic [155:0] data_r;
    logic         vld_r;

    // Extra output stage: data and valid move together, data held between reads.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        data_r <= {156{1'b0}};
        vld_r  <= 1'b0;
      end else begin
        vld_r <= rd_vld_r;
        if (rd_vld_r) begin
          data_r <= rot_s;
        end
      end
    end

    assign iccm_rd_data  = data_r;
    assign iccm_rd_valid = vld_r;
  end else begin : g_nopipe
    assign iccm_rd_data  = rot_s;
    assign iccm_rd_valid = rd_vld_r;
  end

  assign iccm_ready       = ready_r;
  assign iccm_rw_conflict = conflict_r;

endmodule
